// File: rtl/spm_bus_if_pkg.sv
// Shared definitions for the SPM system-bus slave: default widths, bus
// polarities and the 3-bit state encoding of the bus interface FSM.
package spm_bus_if_pkg;

  localparam int unsigned SPM_ADDR_W = 12;
  localparam int unsigned SPM_DATA_W = 32;
  localparam int unsigned SPM_DEPTH  = 2 ** SPM_ADDR_W;

  // Bus polarities: strobes and rdy_ are active-low, rw=1 means read.
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [2:0] {
    SPM_IF_IDLE      = 3'd0,
    SPM_IF_RD_WAIT   = 3'd1,
    SPM_IF_RMW_RD    = 3'd2,
    SPM_IF_RMW_MERGE = 3'd3,
    SPM_IF_DONE      = 3'd4
  } spm_if_state_e;

endpackage

// File: rtl/spm_bus_if.sv
// System-bus slave for the scratchpad memory. Converts single bus
// transactions into accesses on RAM port B; partial writes run as
// read-modify-write because the RAM has no byte enables.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cs_, as_, rw            chip select, address strobe (active-low), read/write
//   addr, be, wr_data       word address, byte enables, write data
//   rd_data, rdy_           read data (0 unless rdy_ low), one-cycle done pulse
//   ram_addr/ram_din/ram_we registered RAM port-B controls
//   ram_dout                RAM port-B read data, one-cycle registered latency
module spm_bus_if
  import spm_bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W = SPM_ADDR_W,
  parameter int unsigned DATA_W = SPM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs_,
  input  logic                as_,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rdy_,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic                ram_we,
  input  logic [DATA_W-1:0]   ram_dout
);

  localparam int unsigned BE_W = DATA_W / 8;

  // Byte-wise merge: enabled lanes take new data, others keep the old word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   en);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (en[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  spm_if_state_e     state_q, state_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_din_d;
  logic              ram_we_d;
  logic              rdy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              accept;

  assign accept = (cs_ == ENABLE_) && (as_ == ENABLE_);

  // RAM output is already registered and lands in the rdy_ cycle, so the
  // read path is gated by a registered valid instead of re-registered.
  assign rd_data = rd_valid_q ? ram_dout : '0;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ram_addr_d = ram_addr;
    ram_din_d  = ram_din;
    ram_we_d   = DISABLE;
    rdy_d      = DISABLE_;
    rd_valid_d = 1'b0;
    unique case (state_q)
      SPM_IF_IDLE: begin
        if (accept) begin
          be_d    = be;
          wdata_d = wr_data;
          if (rw == READ) begin
            ram_addr_d = addr;
            state_d    = SPM_IF_RD_WAIT;
          end else if (be == {BE_W{1'b1}}) begin
            ram_addr_d = addr;
            ram_din_d  = wr_data;
            ram_we_d   = ENABLE;
            rdy_d      = ENABLE_;
          end else if (be == '0) begin
            rdy_d = ENABLE_;
          end else begin
            ram_addr_d = addr;
            state_d    = SPM_IF_RMW_RD;
          end
        end
      end
      SPM_IF_RD_WAIT: begin
        rdy_d      = ENABLE_;
        rd_valid_d = 1'b1;
        state_d    = SPM_IF_IDLE;
      end
      SPM_IF_RMW_RD: begin
        state_d = SPM_IF_RMW_MERGE;
      end
      SPM_IF_RMW_MERGE: begin
        ram_din_d = byte_merge(ram_dout, wdata_q, be_q);
        ram_we_d  = ENABLE;
        rdy_d     = ENABLE_;
        state_d   = SPM_IF_DONE;
      end
      SPM_IF_DONE: begin
        state_d = SPM_IF_IDLE;
      end
      default: begin
        state_d = SPM_IF_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SPM_IF_IDLE;
      be_q       <= '0;
      wdata_q    <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= DISABLE;
      rdy_       <= DISABLE_;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ram_addr   <= ram_addr_d;
      ram_din    <= ram_din_d;
      ram_we     <= ram_we_d;
      rdy_       <= rdy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_spm_bus_if.sv
module tb_spm_bus_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_, as_, rw;
  logic [11:0] addr;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;

  // Port A of the RAM model, driven directly by the bench.
  logic        pa_we;
  logic [11:0] pa_addr;
  logic [31:0] pa_din;

  logic [31:0] mem [0:4095];
  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;

  always #5 clk = ~clk;

  spm_bus_if dut (
    .clk      (clk),
    .reset    (reset),
    .cs_      (cs_),
    .as_      (as_),
    .rw       (rw),
    .addr     (addr),
    .be       (be),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rdy_     (rdy_),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  // Dual-port RAM model, 1-cycle registered read on port B.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    if (pa_we)  mem[pa_addr]  <= pa_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  typedef struct {
    logic        rw;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pa_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pa_we = 1'b1; pa_addr = a; pa_din = d;
    @(negedge clk);
    pa_we = 1'b0;
  endtask

  task automatic strobe(input logic r, input logic [11:0] a, input logic [3:0] b,
                        input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; be = b; wr_data = d;
  endtask

  task automatic idle_bus();
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  // Issue one transaction; lat is the cycle count from accept to rdy_ (-1 on timeout).
  task automatic do_txn(input logic r, input logic [11:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int lat, output logic [31:0] rdat,
                        output logic we_at_rdy);
    lat = -1; rdat = 'x; we_at_rdy = 1'bx;
    @(negedge clk);
    strobe(r, a, b, d);
    @(negedge clk);
    idle_bus();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (rdy_ == 1'b0) begin
        lat = k; rdat = rd_data; we_at_rdy = ram_we;
        break;
      end
    end
  endtask

  initial begin
    int          lat, we0, low_cnt;
    logic [31:0] rdat;
    logic        wer;

    reset = 1'b1; pa_we = 1'b0; pa_addr = '0; pa_din = '0;
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; be = '0; wr_data = '0;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_rdy_", 32'(rdy_), 32'd1);
      chk("reset_ram_we", 32'(ram_we), 32'd0);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    end
    reset = 1'b0;

    pa_write(12'h020, 32'h11223344);
    pa_write(12'h030, 32'h00000005);
    pa_write(12'h050, 32'h00000000);
    pa_write(12'h060, 32'hAAAA0000);

    vecs[0] = '{1'b0, 12'h010, 4'hF, 32'hDEADBEEF, 32'h0,        1, 1};
    vecs[1] = '{1'b1, 12'h010, 4'h0, 32'h0,        32'hDEADBEEF, 2, 0};
    vecs[2] = '{1'b0, 12'h020, 4'h5, 32'hAABBCCDD, 32'h0,        3, 1};
    vecs[3] = '{1'b1, 12'h020, 4'hF, 32'h0,        32'h11BB33DD, 2, 0};
    vecs[4] = '{1'b0, 12'h030, 4'h0, 32'hFFFFFFFF, 32'h0,        1, 0};
    vecs[5] = '{1'b1, 12'h030, 4'h3, 32'h0,        32'h00000005, 2, 0};
    vecs[6] = '{1'b0, 12'h060, 4'h8, 32'h12345678, 32'h0,        3, 1};
    vecs[7] = '{1'b1, 12'h060, 4'h0, 32'h0,        32'h12AA0000, 2, 0};
    vecs[8] = '{1'b0, 12'h050, 4'hE, 32'hCAFEF00D, 32'h0,        3, 1};
    vecs[9] = '{1'b1, 12'h050, 4'h0, 32'h0,        32'hCAFEF000, 2, 0};

    foreach (vecs[i]) begin
      we0 = we_cnt;
      do_txn(vecs[i].rw, vecs[i].addr, vecs[i].be, vecs[i].wdata, lat, rdat, wer);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rd_data", i), rdat, vecs[i].exp_rd);
      chk($sformatf("v%0d_we_at_rdy", i), 32'(wer), 32'(vecs[i].exp_we));
      @(negedge clk);
      chk($sformatf("v%0d_we_count", i), 32'(we_cnt - we0), 32'(vecs[i].exp_we));
    end
    chk("mem_020", mem[12'h020], 32'h11BB33DD);
    chk("mem_030", mem[12'h030], 32'h00000005);

    // Second strobe during RD_WAIT is ignored.
    low_cnt = 0;
    @(negedge clk);
    strobe(1'b1, 12'h010, 4'hF, 32'h0);
    @(negedge clk);
    chk("ign_rd_data_busy", rd_data, 32'h0);
    strobe(1'b1, 12'h020, 4'hF, 32'h0);
    @(negedge clk);
    idle_bus();
    chk("ign_rdy_", 32'(rdy_), 32'd0);
    chk("ign_rd_data", rd_data, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rdy_ == 1'b0) low_cnt++;
    end
    chk("ign_extra_rdy", 32'(low_cnt), 32'd0);

    // Reset during RMW_MERGE drops the write.
    pa_write(12'h040, 32'h01020304);
    we0 = we_cnt; low_cnt = 0;
    @(negedge clk);
    strobe(1'b0, 12'h040, 4'h3, 32'hFFFFFFFF);
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ram_we", 32'(ram_we), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (rdy_ == 1'b0) low_cnt++;
      @(negedge clk);
    end
    chk("rst_mid_rdy", 32'(low_cnt), 32'd0);
    chk("rst_mid_we_count", 32'(we_cnt - we0), 32'd0);
    chk("rst_mid_mem", mem[12'h040], 32'h01020304);

    // Port-A and port-B writes to different words in the same cycle.
    @(negedge clk);
    strobe(1'b0, 12'h080, 4'hF, 32'h88888888);
    @(negedge clk);
    idle_bus();
    pa_we = 1'b1; pa_addr = 12'h070; pa_din = 32'h77777777;
    chk("dual_ram_we", 32'(ram_we), 32'd1);
    chk("dual_rdy_", 32'(rdy_), 32'd0);
    @(negedge clk);
    pa_we = 1'b0;
    @(negedge clk);
    chk("dual_mem_070", mem[12'h070], 32'h77777777);
    chk("dual_mem_080", mem[12'h080], 32'h88888888);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
